// File: rtl/demux_1_4_stream_pkg.sv
// rtl/demux_1_4_stream_pkg.sv - shared constants, port index type and stage state encoding for the 1:4 stream demux
package demux_pkg;

  localparam int PORT_COUNT = 4;
  localparam int SEL_W      = 2;

  typedef logic [SEL_W-1:0] port_idx_t;

  // Occupancy of the single pipeline stage
  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } stage_state_e;

endpackage

// File: rtl/demux_1_4_stream_if.sv
// rtl/demux_1_4_stream_if.sv - producer/consumer handshake bundle for the 1:4 stream demux
interface demux_1_4_stream_if
  import demux_pkg::*;
#(
  parameter int WIDTH = 4
);

  logic                  inValid;
  logic                  inReady;
  logic [WIDTH-1:0]      inputData;
  logic [PORT_COUNT-1:0] outValid;
  logic [PORT_COUNT-1:0] outReady;
  logic [WIDTH-1:0]      outputData;

  // Demux view: consumes the producer stream, drives the four sinks
  modport slave (
    input  inValid,
    input  inputData,
    output inReady,
    output outValid,
    output outputData,
    input  outReady
  );

  // Environment view: producer plus the four sinks
  modport master (
    output inValid,
    output inputData,
    input  inReady,
    input  outValid,
    input  outputData,
    output outReady
  );

endinterface

// File: rtl/demux_1_4_stream_sat_counter.sv
// rtl/demux_1_4_stream_sat_counter.sv - saturating event counter with synchronous clear
module sat_counter #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  // Clear wins over a same-cycle increment; stick at all-ones
  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (inc && (count_q != {CNT_W{1'b1}})) begin
      count_d = count_q + 1'b1;
    end
  end

  // Counter register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/demux_1_4_stream.sv
// rtl/demux_1_4_stream.sv - registered 1:4 valid/ready demux, optional per-port stats under DEMUX_1_4_STATS_EN
module demux_1_4_stream
  import demux_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int CNT_W = 8
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        flush,
  input  logic                        autoSel,
  input  port_idx_t                   selection,
  demux_1_4_stream_if.slave           bus
`ifdef DEMUX_1_4_STATS_EN
  ,
  output logic [PORT_COUNT*CNT_W-1:0] statCount
`endif
);

  logic [WIDTH-1:0] data_q, data_d;
  port_idx_t        sel_q, sel_d;
  port_idx_t        rr_ptr_q, rr_ptr_d;
  stage_state_e     full_q, full_d;

  logic                  in_ready;
  logic                  accept;
  logic                  drain;
  logic [PORT_COUNT-1:0] out_valid;

  // Only the consumer the held word is routed to can stall the stage
  always_comb begin
    in_ready = !flush && ((full_q == EMPTY) || bus.outReady[sel_q]);
    accept   = bus.inValid && in_ready;
    drain    = (full_q == FULL) && bus.outReady[sel_q];
  end

  // Next state: flush beats accept, accept refills even while draining
  always_comb begin
    data_d   = data_q;
    sel_d    = sel_q;
    rr_ptr_d = rr_ptr_q;
    full_d   = full_q;
    if (flush) begin
      full_d   = EMPTY;
      rr_ptr_d = '0;
    end else if (accept) begin
      data_d = bus.inputData;
      sel_d  = autoSel ? rr_ptr_q : selection;
      full_d = FULL;
      if (autoSel) begin
        rr_ptr_d = rr_ptr_q + 1'b1;
      end
    end else if (drain) begin
      full_d = EMPTY;
    end
  end

  // Stage registers, including the EMPTY/FULL state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q   <= '0;
      sel_q    <= '0;
      rr_ptr_q <= '0;
      full_q   <= EMPTY;
    end else begin
      data_q   <= data_d;
      sel_q    <= sel_d;
      rr_ptr_q <= rr_ptr_d;
      full_q   <= full_d;
    end
  end

  // One-hot valid decoded straight from the registered state
  always_comb begin
    out_valid = '0;
    for (int i = 0; i < PORT_COUNT; i++) begin
      out_valid[i] = (full_q == FULL) && (sel_q == port_idx_t'(i));
    end
  end

  assign bus.inReady    = in_ready;
  assign bus.outValid   = out_valid;
  assign bus.outputData = data_q;

`ifdef DEMUX_1_4_STATS_EN
  for (genvar g = 0; g < PORT_COUNT; g++) begin : g_stats
    sat_counter #(
      .CNT_W (CNT_W)
    ) u_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (flush),
      .inc   (out_valid[g] && bus.outReady[g]),
      .count (statCount[g*CNT_W +: CNT_W])
    );
  end
`endif

endmodule

// File: tb/tb_demux_1_4_stream.sv
// tb/tb_demux_1_4_stream.sv - scoreboard bench for the 1:4 stream demux
module tb_demux_1_4_stream;

  localparam int WIDTH = 4;
  localparam int CNT_W = 2;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       flush;
  logic       autoSel;
  logic [1:0] selection;

  demux_1_4_stream_if #(.WIDTH(WIDTH)) bus ();

`ifdef DEMUX_1_4_STATS_EN
  logic [4*CNT_W-1:0] statCount;
`endif

  demux_1_4_stream #(
    .WIDTH (WIDTH),
    .CNT_W (CNT_W)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .autoSel   (autoSel),
    .selection (selection),
    .bus       (bus.slave)
`ifdef DEMUX_1_4_STATS_EN
    ,
    .statCount (statCount)
`endif
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0]       port;
    logic [WIDTH-1:0] data;
  } exp_t;

  exp_t sb_q[$];
  int   n_cmp = 0;
  int   n_err = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one word, require it to be taken this cycle, optionally expect delivery
  task automatic send(input logic [3:0] d, input logic [1:0] sel, input logic au,
                      input logic [1:0] exp_port, input logic expect_out);
    bus.inValid   = 1'b1;
    bus.inputData = d;
    selection     = sel;
    autoSel       = au;
    @(negedge clk);
    chk("in_ready_send", {31'd0, bus.inReady}, 32'd1);
    if (expect_out) sb_q.push_back('{port: exp_port, data: d});
    tick();
    bus.inValid = 1'b0;
  endtask

  task automatic do_flush();
    flush       = 1'b1;
    bus.inValid = 1'b0;
    tick();
    flush = 1'b0;
  endtask

  // Monitor: every completed transfer must match the oldest expected word
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n && |(bus.outValid & bus.outReady)) begin
        if (sb_q.size() == 0) begin
          chk("unexpected_out", {28'd0, bus.outValid}, 32'd0);
        end else begin
          e = sb_q.pop_front();
          chk("out_valid", {28'd0, bus.outValid}, 32'd1 << e.port);
          chk("out_data", {28'd0, bus.outputData}, {28'd0, e.data});
        end
      end
    end
  end

  initial begin
    rst_n         = 1'b0;
    flush         = 1'b0;
    autoSel       = 1'b1;
    selection     = 2'd3;
    bus.inValid   = 1'b1;
    bus.inputData = 4'hF;
    bus.outReady  = 4'b1111;

    // 1. Reset holds the stage empty even with a word presented
    repeat (3) begin
      @(negedge clk);
      chk("rst_out_valid", {28'd0, bus.outValid}, 32'd0);
      chk("rst_out_data", {28'd0, bus.outputData}, 32'd0);
      chk("rst_in_ready", {31'd0, bus.inReady}, 32'd1);
    end
    bus.inValid = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    send(4'h9, 2'd3, 1'b1, 2'd0, 1'b1);
    tick();

    // 2. Directed routing back to back
    send(4'hA, 2'd2, 1'b0, 2'd2, 1'b1);
    send(4'h5, 2'd0, 1'b0, 2'd0, 1'b1);
    tick();

    // 3. Backpressure on port 1 while another word waits
    send(4'h3, 2'd1, 1'b0, 2'd1, 1'b1);
    bus.outReady  = 4'b1101;
    bus.inValid   = 1'b1;
    bus.inputData = 4'h7;
    selection     = 2'd3;
    repeat (4) begin
      @(negedge clk);
      chk("bp_out_valid", {28'd0, bus.outValid}, 32'h2);
      chk("bp_out_data", {28'd0, bus.outputData}, 32'h3);
      chk("bp_in_ready", {31'd0, bus.inReady}, 32'd0);
      tick();
    end
    bus.outReady = 4'b1111;
    send(4'h7, 2'd3, 1'b0, 2'd3, 1'b1);
    tick();

    // 4. Round-robin, interrupted by two directed words
    do_flush();
    send(4'h1, 2'd3, 1'b1, 2'd0, 1'b1);
    send(4'h2, 2'd3, 1'b1, 2'd1, 1'b1);
    send(4'h3, 2'd3, 1'b1, 2'd2, 1'b1);
    send(4'h4, 2'd0, 1'b1, 2'd3, 1'b1);
    send(4'h5, 2'd3, 1'b1, 2'd0, 1'b1);
    send(4'h6, 2'd3, 1'b1, 2'd1, 1'b1);
    send(4'h8, 2'd1, 1'b0, 2'd1, 1'b1);
    send(4'h9, 2'd3, 1'b0, 2'd3, 1'b1);
    send(4'hB, 2'd0, 1'b1, 2'd2, 1'b1);
    tick();

    // 5. Flush discards the held word and blocks the incoming one
    bus.outReady = 4'b0111;
    send(4'hC, 2'd3, 1'b0, 2'd3, 1'b0);
    @(negedge clk);
    chk("pre_flush_valid", {28'd0, bus.outValid}, 32'h8);
    tick();
    flush         = 1'b1;
    bus.inValid   = 1'b1;
    bus.inputData = 4'hE;
    selection     = 2'd1;
    autoSel       = 1'b0;
    @(negedge clk);
    chk("flush_in_ready", {31'd0, bus.inReady}, 32'd0);
    tick();
    flush       = 1'b0;
    bus.inValid = 1'b0;
    @(negedge clk);
    chk("post_flush_valid", {28'd0, bus.outValid}, 32'd0);
    tick();
    bus.outReady = 4'b1111;
    send(4'hD, 2'd3, 1'b1, 2'd0, 1'b1);
    tick();

`ifdef DEMUX_1_4_STATS_EN
    // 6. Per-port counters saturate, then flush clears them
    do_flush();
    repeat (5) send(4'h6, 2'd2, 1'b0, 2'd2, 1'b1);
    tick();
    tick();
    @(negedge clk);
    chk("stat_p0", {30'd0, statCount[0*CNT_W +: CNT_W]}, 32'd0);
    chk("stat_p1", {30'd0, statCount[1*CNT_W +: CNT_W]}, 32'd0);
    chk("stat_p2", {30'd0, statCount[2*CNT_W +: CNT_W]}, 32'd3);
    chk("stat_p3", {30'd0, statCount[3*CNT_W +: CNT_W]}, 32'd0);
    tick();
    do_flush();
    @(negedge clk);
    chk("stat_flushed", {24'd0, statCount}, 32'd0);
`endif

    // Let the scoreboard drain, bounded
    for (int i = 0; i < 50 && sb_q.size() != 0; i++) tick();
    chk("sb_drained", sb_q.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
